multi_ball_hit_controller: RTL and testbench

Frame-based collision resolver for N balls, parametrised in ball count, hole count and velocity width. It adds ball-to-ball collisions and hole capture to border handling, with fixed priority muxing between collision sources. Pixel-level overlaps are accumulated during each frame. At frame start a sequential resolver walks the balls one per cycle and publishes new velocities, hole hits and collision flags to the ball movement blocks.

---
 rtl/hit_pkg.sv | 36 +++
 rtl/collision_flag_accumulator.sv | 58 +++++
 rtl/multi_ball_hit_controller.sv | 163 ++++++++++++++++
 tb/tb_multi_ball_hit_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_pkg.sv
// Shared types and helpers for the multi-ball hit controller: resolver states,
// saturating negation and a small priority encoder.
package hit_pkg;

    localparam int MAX_BALLS     = 8;
    localparam int MAX_HOLES     = 8;
    localparam int VEL_W_DEFAULT = 11;

    typedef logic signed [VEL_W_DEFAULT-1:0] vel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } resolver_state_e;

    // Negate a w-bit signed value held sign-extended in 32 bits; the most
    // negative w-bit value maps to the most positive one instead of wrapping.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (w - 1));
        if (v == min_v)
            return -(min_v + 32'sd1);
        return -v;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [MAX_HOLES-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int k = MAX_HOLES - 1; k >= 0; k--)
            if (v[k])
                r = 3'(k);
        return r;
    endfunction

endpackage

// File: rtl/collision_flag_accumulator.sv
// Sticky per-frame overlap flags (border, hole, ball pair) with a
// snapshot-and-clear on capture; the capture cycle's overlap seeds the new set.
module collision_flag_accumulator
    import hit_pkg::*;
#(
    parameter int NUM_BALLS = 2,
    parameter int NUM_HOLES = 6
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 capture,
    input  logic [NUM_BALLS-1:0]                 ballDR,
    input  logic                                 bordersDR,
    input  logic [NUM_HOLES-1:0]                 holeDR,
    output logic [NUM_BALLS-1:0]                 snapBorder,
    output logic [NUM_BALLS-1:0][NUM_HOLES-1:0]  snapHole,
    output logic [NUM_BALLS-1:0][NUM_BALLS-1:0]  snapPair
);

    logic [NUM_BALLS-1:0]                curBorder, accBorder;
    logic [NUM_BALLS-1:0][NUM_HOLES-1:0] curHole, accHole;
    logic [NUM_BALLS-1:0][NUM_BALLS-1:0] curPair, accPair;

    // Pair flags are kept as a symmetric matrix so either ball can look up its partner.
    always_comb begin
        curBorder = ballDR & {NUM_BALLS{bordersDR}};
        curHole   = '0;
        curPair   = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            curHole[i] = {NUM_HOLES{ballDR[i]}} & holeDR;
            for (int j = 0; j < NUM_BALLS; j++)
                curPair[i][j] = (i != j) && ballDR[i] && ballDR[j];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            accBorder  <= '0;
            accHole    <= '0;
            accPair    <= '0;
            snapBorder <= '0;
            snapHole   <= '0;
            snapPair   <= '0;
        end else if (capture) begin
            snapBorder <= accBorder;
            snapHole   <= accHole;
            snapPair   <= accPair;
            accBorder  <= curBorder;
            accHole    <= curHole;
            accPair    <= curPair;
        end else begin
            accBorder  <= accBorder | curBorder;
            accHole    <= accHole | curHole;
            accPair    <= accPair | curPair;
        end
    end

endmodule

// File: rtl/multi_ball_hit_controller.sv
// Frame-based collision resolver: walks the balls one per cycle after each
// frame start and publishes velocities, hole captures and collision flags.
module multi_ball_hit_controller
    import hit_pkg::*;
#(
    parameter int NUM_BALLS    = 2,
    parameter int NUM_HOLES    = 6,
    parameter int VEL_W        = 11,
    parameter int TOP_OFFSET   = 0,
    parameter int DOWN_OFFSET  = 479,
    parameter int LEFT_OFFSET  = 0,
    parameter int RIGHT_OFFSET = 639
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  logic [NUM_BALLS-1:0]              ballDR,
    input  logic                              bordersDR,
    input  logic [NUM_HOLES-1:0]              holeDR,
    input  logic [NUM_BALLS-1:0][VEL_W-1:0]   ballPosX,
    input  logic [NUM_BALLS-1:0][VEL_W-1:0]   ballPosY,
    input  logic [NUM_BALLS-1:0][VEL_W-1:0]   ballVelX,
    input  logic [NUM_BALLS-1:0][VEL_W-1:0]   ballVelY,
    output logic [NUM_BALLS-1:0][VEL_W-1:0]   ballVelXOut,
    output logic [NUM_BALLS-1:0][VEL_W-1:0]   ballVelYOut,
    output logic [NUM_BALLS-1:0]              collisionOccurred,
    output logic [NUM_BALLS-1:0]              holeHit,
    output logic [NUM_BALLS-1:0][2:0]         holeNum,
    output logic                              resolveDone,
    output resolver_state_e                   dbgState
);

    localparam int IDX_W = $clog2(NUM_BALLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);
    localparam logic signed [VEL_W-1:0] MID_X = VEL_W'((LEFT_OFFSET + RIGHT_OFFSET) / 2);
    localparam logic signed [VEL_W-1:0] MID_Y = VEL_W'((TOP_OFFSET + DOWN_OFFSET) / 2);

    resolver_state_e state;
    logic [IDX_W-1:0] idx;
    logic [NUM_BALLS-1:0][VEL_W-1:0] snapPosX, snapPosY, snapVelX, snapVelY;

    logic                                capture;
    logic [NUM_BALLS-1:0]                snapBorder;
    logic [NUM_BALLS-1:0][NUM_HOLES-1:0] snapHole;
    logic [NUM_BALLS-1:0][NUM_BALLS-1:0] snapPair;

    assign capture  = startOfFrame && (state == IDLE);
    assign dbgState = state;

    collision_flag_accumulator #(
        .NUM_BALLS (NUM_BALLS),
        .NUM_HOLES (NUM_HOLES)
    ) u_acc (
        .clk        (clk),
        .resetN     (resetN),
        .capture    (capture),
        .ballDR     (ballDR),
        .bordersDR  (bordersDR),
        .holeDR     (holeDR),
        .snapBorder (snapBorder),
        .snapHole   (snapHole),
        .snapPair   (snapPair)
    );

    logic [NUM_BALLS-1:0]        holed, partners;
    logic [MAX_BALLS-1:0]        partnerPad;
    logic [MAX_HOLES-1:0]        holePad;
    logic [IDX_W-1:0]            partnerIdx;
    logic signed [VEL_W-1:0]     vx, vy, px, py;
    logic                        flipX, flipY;
    logic [VEL_W-1:0]            nextVx, nextVy;
    logic                        nextHit, nextCol;
    logic [2:0]                  nextNum;

    // Priority for the ball at idx: hole, then un-holed pair partner, then border.
    always_comb begin
        for (int j = 0; j < NUM_BALLS; j++)
            holed[j] = |snapHole[j];
        partners   = snapPair[idx] & ~holed;
        partnerPad = '0;
        partnerPad[NUM_BALLS-1:0] = partners;
        partnerIdx = IDX_W'(lowest_set(partnerPad));
        holePad    = '0;
        holePad[NUM_HOLES-1:0] = snapHole[idx];

        vx = snapVelX[idx];
        vy = snapVelY[idx];
        px = snapPosX[idx];
        py = snapPosY[idx];
        flipX = (vx[VEL_W-1] && (px < MID_X)) || (!vx[VEL_W-1] && (vx != '0) && (px >= MID_X));
        flipY = (vy[VEL_W-1] && (py < MID_Y)) || (!vy[VEL_W-1] && (vy != '0) && (py >= MID_Y));

        nextVx  = vx;
        nextVy  = vy;
        nextHit = 1'b0;
        nextNum = 3'd0;
        nextCol = 1'b0;
        if (holed[idx]) begin
            nextVx  = '0;
            nextVy  = '0;
            nextHit = 1'b1;
            nextNum = lowest_set(holePad);
            nextCol = 1'b1;
        end else if (|partners) begin
            nextVx  = snapVelX[partnerIdx];
            nextVy  = snapVelY[partnerIdx];
            nextCol = 1'b1;
        end else if (snapBorder[idx]) begin
            if (flipX)
                nextVx = VEL_W'(sat_neg(32'(vx), VEL_W));
            if (flipY)
                nextVy = VEL_W'(sat_neg(32'(vy), VEL_W));
            nextCol = flipX || flipY;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state             <= IDLE;
            idx               <= '0;
            resolveDone       <= 1'b0;
            snapPosX          <= '0;
            snapPosY          <= '0;
            snapVelX          <= '0;
            snapVelY          <= '0;
            ballVelXOut       <= '0;
            ballVelYOut       <= '0;
            collisionOccurred <= '0;
            holeHit           <= '0;
            holeNum           <= '0;
        end else begin
            resolveDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (startOfFrame) begin
                        snapPosX <= ballPosX;
                        snapPosY <= ballPosY;
                        snapVelX <= ballVelX;
                        snapVelY <= ballVelY;
                        idx      <= '0;
                        state    <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    ballVelXOut[idx]       <= nextVx;
                    ballVelYOut[idx]       <= nextVy;
                    collisionOccurred[idx] <= nextCol;
                    holeHit[idx]           <= nextHit;
                    holeNum[idx]           <= nextNum;
                    if (idx == LAST_IDX) begin
                        state       <= DONE;
                        resolveDone <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// Bench for multi_ball_hit_controller: directed overlap frames checked against
// a frame-level behavioural model plus hand-computed literal expectations.
module tb_multi_ball_hit_controller;
    import hit_pkg::*;

    localparam int NB    = 2;
    localparam int NH    = 6;
    localparam int VW    = 11;
    localparam int MID_X = 319;
    localparam int MID_Y = 239;

    // clock / reset
    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    logic                     startOfFrame = 1'b0;
    logic [NB-1:0]            ballDR = '0;
    logic                     bordersDR = 1'b0;
    logic [NH-1:0]            holeDR = '0;
    logic [NB-1:0][VW-1:0]    ballPosX = '0, ballPosY = '0, ballVelX = '0, ballVelY = '0;
    logic [NB-1:0][VW-1:0]    ballVelXOut, ballVelYOut;
    logic [NB-1:0]            collisionOccurred, holeHit;
    logic [NB-1:0][2:0]       holeNum;
    logic                     resolveDone;
    resolver_state_e          dbgState;

    multi_ball_hit_controller #(.NUM_BALLS(NB), .NUM_HOLES(NH), .VEL_W(VW)) dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .ballDR            (ballDR),
        .bordersDR         (bordersDR),
        .holeDR            (holeDR),
        .ballPosX          (ballPosX),
        .ballPosY          (ballPosY),
        .ballVelX          (ballVelX),
        .ballVelY          (ballVelY),
        .ballVelXOut       (ballVelXOut),
        .ballVelYOut       (ballVelYOut),
        .collisionOccurred (collisionOccurred),
        .holeHit           (holeHit),
        .holeNum           (holeNum),
        .resolveDone       (resolveDone),
        .dbgState          (dbgState)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int to_int(input logic [VW-1:0] x);
        return int'($signed(x));
    endfunction

    function automatic int neg_sat(input int v);
        return (v == -(1 << (VW - 1))) ? (1 << (VW - 1)) - 1 : -v;
    endfunction

    // model: frame accumulators, expected-result queue, published outputs
    typedef struct {
        int vx;
        int vy;
        int hn;
        bit hh;
        bit col;
    } res_t;

    bit   a_border[NB];
    bit   a_hole[NB][NH];
    bit   a_pair[NB][NB];
    res_t exp_q[$];
    int   e_vx[NB], e_vy[NB], e_hn[NB];
    bit   e_hh[NB], e_col[NB];
    bit   e_done = 1'b0;
    int   phase = -1;
    bit   was_idle;

    function automatic void compute_frame();
        bit   holed[NB];
        res_t r;
        int   p, vx, vy, px, py;
        for (int i = 0; i < NB; i++) begin
            holed[i] = 1'b0;
            for (int h = 0; h < NH; h++)
                if (a_hole[i][h]) holed[i] = 1'b1;
        end
        for (int i = 0; i < NB; i++) begin
            r  = '{default: 0};
            vx = to_int(ballVelX[i]);
            vy = to_int(ballVelY[i]);
            px = to_int(ballPosX[i]);
            py = to_int(ballPosY[i]);
            if (holed[i]) begin
                r.hh  = 1'b1;
                r.col = 1'b1;
                for (int h = NH - 1; h >= 0; h--)
                    if (a_hole[i][h]) r.hn = h;
            end else begin
                p = -1;
                for (int j = NB - 1; j >= 0; j--)
                    if (j != i && a_pair[i][j] && !holed[j]) p = j;
                if (p >= 0) begin
                    r.vx  = to_int(ballVelX[p]);
                    r.vy  = to_int(ballVelY[p]);
                    r.col = 1'b1;
                end else begin
                    r.vx = vx;
                    r.vy = vy;
                    if (a_border[i]) begin
                        if ((vx < 0 && px < MID_X) || (vx > 0 && px >= MID_X)) begin
                            r.vx  = neg_sat(vx);
                            r.col = 1'b1;
                        end
                        if ((vy < 0 && py < MID_Y) || (vy > 0 && py >= MID_Y)) begin
                            r.vy  = neg_sat(vy);
                            r.col = 1'b1;
                        end
                    end
                end
            end
            exp_q.push_back(r);
        end
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            exp_q.delete();
            phase  = -1;
            e_done = 1'b0;
            for (int i = 0; i < NB; i++) begin
                e_vx[i] = 0; e_vy[i] = 0; e_hn[i] = 0; e_hh[i] = 0; e_col[i] = 0;
                a_border[i] = 0;
                for (int h = 0; h < NH; h++) a_hole[i][h] = 0;
                for (int j = 0; j < NB; j++) a_pair[i][j] = 0;
            end
        end else begin
            was_idle = (phase < 0);
            if (phase >= 0 && phase < NB) begin
                res_t r;
                r = exp_q.pop_front();
                e_vx[phase] = r.vx; e_vy[phase] = r.vy; e_hn[phase] = r.hn;
                e_hh[phase] = r.hh; e_col[phase] = r.col;
                if (phase == NB - 1) e_done = 1'b1;
                phase++;
            end else if (phase == NB) begin
                e_done = 1'b0;
                phase  = -1;
            end
            if (was_idle && startOfFrame) begin
                compute_frame();
                phase = 0;
                for (int i = 0; i < NB; i++) begin
                    a_border[i] = 0;
                    for (int h = 0; h < NH; h++) a_hole[i][h] = 0;
                    for (int j = 0; j < NB; j++) a_pair[i][j] = 0;
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (ballDR[i] && bordersDR) a_border[i] = 1'b1;
                for (int h = 0; h < NH; h++)
                    if (ballDR[i] && holeDR[h]) a_hole[i][h] = 1'b1;
                for (int j = 0; j < NB; j++)
                    if (i != j && ballDR[i] && ballDR[j]) a_pair[i][j] = 1'b1;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("vx[%0d]", i), to_int(ballVelXOut[i]), e_vx[i]);
            check($sformatf("vy[%0d]", i), to_int(ballVelYOut[i]), e_vy[i]);
            check($sformatf("col[%0d]", i), int'(collisionOccurred[i]), int'(e_col[i]));
            check($sformatf("hh[%0d]", i), int'(holeHit[i]), int'(e_hh[i]));
            check($sformatf("hn[%0d]", i), int'(holeNum[i]), e_hn[i]);
        end
        check("done", int'(resolveDone), int'(e_done));
        check("state", int'(dbgState), (phase < 0) ? 0 : (phase < NB) ? 1 : 2);
    end

    // driver tasks
    task automatic set_ball(input int i, input int px, input int py, input int vx, input int vy);
        ballPosX[i] = VW'(px);
        ballPosY[i] = VW'(py);
        ballVelX[i] = VW'(vx);
        ballVelY[i] = VW'(vy);
    endtask

    task automatic overlap(input logic [NB-1:0] b, input logic bd, input logic [NH-1:0] h);
        ballDR    = b;
        bordersDR = bd;
        holeDR    = h;
        @(negedge clk);
        ballDR    = '0;
        bordersDR = 1'b0;
        holeDR    = '0;
    endtask

    task automatic pulse_frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    int done_cnt;

    initial begin
        #2 resetN = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_vx0", to_int(ballVelXOut[0]), 0);
        check("rst_done", int'(resolveDone), 0);
        check("rst_state", int'(dbgState), 0);
        resetN = 1'b1;
        @(negedge clk);

        // border bounce on the left edge
        set_ball(0, 5, 100, -3, 2);
        set_ball(1, 300, 300, 1, 1);
        overlap(2'b01, 1'b1, '0);
        pulse_frame();
        @(negedge clk); #1;
        check("t1_vx0", to_int(ballVelXOut[0]), 3);
        check("t1_vy0", to_int(ballVelYOut[0]), 2);
        check("t1_col0", int'(collisionOccurred[0]), 1);
        check("t1_mdl_vx0", e_vx[0], 3);
        check("t1_done_low", int'(resolveDone), 0);
        @(negedge clk); #1;
        check("t1_done", int'(resolveDone), 1);
        check("t1_vx1", to_int(ballVelXOut[1]), 1);
        @(negedge clk); #1;
        check("t1_done_end", int'(resolveDone), 0);

        // hole beats border
        set_ball(1, 600, 400, 5, 5);
        overlap(2'b10, 1'b1, 6'b010000);
        pulse_frame();
        settle();
        check("t2_vx1", to_int(ballVelXOut[1]), 0);
        check("t2_vy1", to_int(ballVelYOut[1]), 0);
        check("t2_hh1", int'(holeHit[1]), 1);
        check("t2_hn1", int'(holeNum[1]), 4);
        check("t2_col0", int'(collisionOccurred[0]), 0);
        check("t2_mdl_hn1", e_hn[1], 4);
        @(negedge clk);

        // ball-ball swap
        set_ball(0, 100, 100, 4, 0);
        set_ball(1, 110, 100, -2, 1);
        overlap(2'b11, 1'b0, '0);
        pulse_frame();
        settle();
        check("t3_vx0", to_int(ballVelXOut[0]), -2);
        check("t3_vy0", to_int(ballVelYOut[0]), 1);
        check("t3_vx1", to_int(ballVelXOut[1]), 4);
        check("t3_vy1", to_int(ballVelYOut[1]), 0);
        check("t3_col", int'(collisionOccurred), 3);
        check("t3_hn1", int'(holeNum[1]), 0);
        @(negedge clk);

        // saturating negation
        set_ball(0, 2, 50, -1024, 0);
        overlap(2'b01, 1'b1, '0);
        pulse_frame();
        settle();
        check("t4_vx0", to_int(ballVelXOut[0]), 1023);
        check("t4_vy0", to_int(ballVelYOut[0]), 0);
        check("t4_mdl_vx0", e_vx[0], 1023);
        @(negedge clk);

        // holed ball hides its pair contact; partner bounces off the right/top
        set_ball(0, 100, 100, 4, 4);
        set_ball(1, 630, 200, 3, -2);
        overlap(2'b01, 1'b0, 6'b000100);
        overlap(2'b11, 1'b0, '0);
        overlap(2'b10, 1'b1, '0);
        pulse_frame();
        settle();
        check("t5_hh0", int'(holeHit[0]), 1);
        check("t5_hn0", int'(holeNum[0]), 2);
        check("t5_vx1", to_int(ballVelXOut[1]), -3);
        check("t5_vy1", to_int(ballVelYOut[1]), 2);
        check("t5_col1", int'(collisionOccurred[1]), 1);
        @(negedge clk);

        // second frame start during resolve is ignored; its overlap carries over
        set_ball(0, 5, 100, -3, 2);
        set_ball(1, 300, 300, 1, 1);
        overlap(2'b01, 1'b1, '0);
        pulse_frame();
        startOfFrame = 1'b1;
        ballDR       = 2'b11;
        @(negedge clk);
        startOfFrame = 1'b0;
        ballDR       = '0;
        done_cnt     = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (resolveDone) done_cnt++;
            @(negedge clk);
        end
        check("t6_done_pulses", done_cnt, 1);
        check("t6_vx0", to_int(ballVelXOut[0]), 3);
        pulse_frame();
        settle();
        check("t6_next_vx0", to_int(ballVelXOut[0]), 1);
        check("t6_next_vx1", to_int(ballVelXOut[1]), -3);
        check("t6_next_vy1", to_int(ballVelYOut[1]), 2);
        @(negedge clk);

        // reset in the middle of a resolve
        overlap(2'b01, 1'b1, '0);
        pulse_frame();
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("t7_vx0", to_int(ballVelXOut[0]), 0);
        check("t7_col", int'(collisionOccurred), 0);
        check("t7_state", int'(dbgState), 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        set_ball(1, 630, 200, 3, -2);
        overlap(2'b10, 1'b1, '0);
        pulse_frame();
        settle();
        check("t7_next_vx1", to_int(ballVelXOut[1]), -3);
        check("t7_next_vy1", to_int(ballVelYOut[1]), 2);
        check("t7_next_vx0", to_int(ballVelXOut[0]), -3);
        check("t7_next_col0", int'(collisionOccurred[0]), 0);

        repeat (4) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
